exc_ctrl: RTL and testbench

Exception/interrupt controller (CP0 core) for the five-stage MIPS pipeline. It samples the exception code carried into the M stage, the hardware interrupt lines and the SR mask. It decides whether to take an exception or interrupt, and holds the SR, Cause, EPC and PRId registers. It drives the flush/redirect request to the pipeline and sequences handler entry and `eret` return through a three-state machine.

---
 rtl/exc_ctrl_pkg.sv | 21 ++
 rtl/exc_ctrl_prio.sv | 33 +++
 rtl/exc_ctrl.sv | 144 ++++++++++++++
 tb/tb_exc_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 constants: exception codes, register numbers and FSM states.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_RETURN  = 2'd2
    } state_e;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational resolution of pending interrupt/exception into a request,
// the ExcCode to record and the EPC to save.
import exc_ctrl_pkg::*;

module exc_prio (
    input  logic        ie,
    input  logic        exl,
    input  logic [5:0]  im,
    input  logic [5:0]  hw_int,
    input  logic        in_run,
    input  logic [4:0]  exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    output logic        int_pend,
    output logic        exc_pend,
    output logic        req,
    output logic [4:0]  sel_code,
    output logic [31:0] epc_val
);

    logic [31:0] pc_word;

    // Interrupts win over exceptions; a delay-slot instruction restarts at its branch.
    always_comb begin
        int_pend = ie & ~exl & (|(hw_int & im)) & in_run;
        exc_pend = (exc_code != EXC_INT) & ~exl;
        req      = int_pend | exc_pend;
        sel_code = int_pend ? EXC_INT : exc_code;
        pc_word  = m_pc & 32'hFFFF_FFFC;
        epc_val  = m_bd ? (pc_word - 32'd4) : pc_word;
    end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 core: SR/Cause/EPC/PRId, exception entry and eret return sequencing.
import exc_ctrl_pkg::*;

module exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        eret,
    output logic [31:0] rdata,
    output logic        req,
    output logic [31:0] target_pc,
    output logic [31:0] epc_out,
    output logic        exl
);

    state_e      state_q, state_d;
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_code_q, cause_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend, exc_pend;
    logic [4:0]  sel_code;
    logic [31:0] epc_val;
    logic        eret_acc, sr_wr;

    exc_prio u_prio (
        .ie       (sr_ie_q),
        .exl      (sr_exl_q),
        .im       (sr_im_q),
        .hw_int   (hw_int),
        .in_run   (state_q == ST_RUN),
        .exc_code (exc_code),
        .m_pc     (m_pc),
        .m_bd     (m_bd),
        .int_pend (int_pend),
        .exc_pend (exc_pend),
        .req      (req),
        .sel_code (sel_code),
        .epc_val  (epc_val)
    );

    assign eret_acc  = eret & ~req & sr_exl_q;
    assign sr_wr     = we & ~req & (addr == CP0_SR);
    assign target_pc = req ? HANDLER_PC : epc_q;
    assign epc_out   = epc_q;
    assign exl       = sr_exl_q;

    // CP0 register next values: exception entry overrides mtc0; eret clears EXL.
    always_comb begin
        sr_im_d      = sr_im_q;
        sr_exl_d     = sr_exl_q;
        sr_ie_d      = sr_ie_q;
        cause_bd_d   = cause_bd_q;
        cause_ip_d   = hw_int;
        cause_code_d = cause_code_q;
        epc_d        = epc_q;
        if (req) begin
            sr_exl_d     = 1'b1;
            cause_code_d = sel_code;
            cause_bd_d   = m_bd;
            epc_d        = epc_val;
        end else begin
            if (we) begin
                case (addr)
                    CP0_SR: begin
                        sr_im_d  = wdata[15:10];
                        sr_exl_d = wdata[1];
                        sr_ie_d  = wdata[0];
                    end
                    CP0_EPC: epc_d = wdata & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            if (eret_acc) sr_exl_d = 1'b0;
        end
    end

    // FSM next state; kept in step with EXL (HANDLER exactly when EXL is set).
    always_comb begin
        state_d = state_q;
        if (req) begin
            state_d = ST_HANDLER;
        end else begin
            case (state_q)
                ST_RUN:     if (sr_wr && wdata[1]) state_d = ST_HANDLER;
                ST_HANDLER: begin
                    if (eret_acc)                 state_d = ST_RETURN;
                    else if (sr_wr && !wdata[1])  state_d = ST_RUN;
                end
                ST_RETURN:  state_d = (sr_wr && wdata[1]) ? ST_HANDLER : ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    // State and register flops, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            sr_im_q      <= '0;
            sr_exl_q     <= 1'b0;
            sr_ie_q      <= 1'b0;
            cause_bd_q   <= 1'b0;
            cause_ip_q   <= '0;
            cause_code_q <= '0;
            epc_q        <= '0;
        end else begin
            state_q      <= state_d;
            sr_im_q      <= sr_im_d;
            sr_exl_q     <= sr_exl_d;
            sr_ie_q      <= sr_ie_d;
            cause_bd_q   <= cause_bd_d;
            cause_ip_q   <= cause_ip_d;
            cause_code_q <= cause_code_d;
            epc_q        <= epc_d;
        end
    end

    // mfc0 read mux; unmapped numbers read zero.
    always_comb begin
        rdata = '0;
        case (addr)
            CP0_SR:    rdata = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
            CP0_CAUSE: rdata = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_code_q, 2'b0};
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID_VAL;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: driver pushes model predictions, monitor checks at negedge.
module tb_exc_ctrl;

    localparam logic [31:0] HPC  = 32'h0000_4180;
    localparam logic [31:0] PRID = 32'h0000_8A01;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  exc_code;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] target_pc;
    logic [31:0] epc_out;
    logic        exl;

    exc_ctrl #(.HANDLER_PC(HPC), .PRID_VAL(PRID)) dut (
        .clk(clk), .reset(reset), .exc_code(exc_code), .m_pc(m_pc), .m_bd(m_bd),
        .hw_int(hw_int), .we(we), .addr(addr), .wdata(wdata), .eret(eret),
        .rdata(rdata), .req(req), .target_pc(target_pc), .epc_out(epc_out), .exl(exl)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        req;
        logic        chk_tgt;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic [31:0] epc;
        logic        exl;
    } exp_t;
    exp_t q[$];

    // architectural model of CP0 state
    logic [5:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bdr, m_retblk;
    logic [4:0]  m_code;
    logic [31:0] m_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    task automatic model_reset();
        m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bdr = 0; m_retblk = 0;
        m_code = '0; m_epc = '0;
    endtask

    // one M-stage cycle: drive, predict, advance the model
    task automatic cyc(input logic [4:0] ec, input logic [31:0] pc, input logic bd,
                       input logic [5:0] hw, input logic w, input logic [4:0] a,
                       input logic [31:0] wd, input logic er);
        exp_t e;
        logic ip_, ep_, r_, acc;
        @(posedge clk); #1;
        exc_code = ec; m_pc = pc; m_bd = bd; hw_int = hw; we = w; addr = a; wdata = wd; eret = er;
        ip_ = m_ie && !m_exl && ((hw & m_im) != 0) && !m_retblk;
        ep_ = (ec != 0) && !m_exl;
        r_  = ip_ || ep_;
        acc = er && !r_ && m_exl;
        e.req = r_;
        e.chk_tgt = r_ || acc;
        e.tgt = r_ ? HPC : m_epc;
        case (a)
            5'd12:   e.rdata = {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   e.rdata = {m_bdr, 15'b0, m_ip, 3'b0, m_code, 2'b0};
            5'd14:   e.rdata = m_epc;
            5'd15:   e.rdata = PRID;
            default: e.rdata = 32'd0;
        endcase
        e.epc = m_epc;
        e.exl = m_exl;
        q.push_back(e);
        m_ip = hw;
        if (r_) begin
            m_exl  = 1'b1;
            m_code = ip_ ? 5'd0 : ec;
            m_bdr  = bd;
            m_epc  = bd ? {pc[31:2], 2'b00} - 32'd4 : {pc[31:2], 2'b00};
        end else begin
            if (w && a == 5'd12) begin
                m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
            end
            if (w && a == 5'd14) m_epc = {wd[31:2], 2'b00};
            if (acc) m_exl = 1'b0;
        end
        m_retblk = acc;
    endtask

    // monitor: compare whatever the driver predicted for this cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("req", {31'b0, req}, {31'b0, e.req});
            if (e.chk_tgt) chk("target_pc", target_pc, e.tgt);
            chk("rdata", rdata, e.rdata);
            chk("epc_out", epc_out, e.epc);
            chk("exl", {31'b0, exl}, {31'b0, e.exl});
        end
    end

    task automatic idle(input logic [4:0] a);
        cyc(5'd0, 32'h0000_3000, 1'b0, 6'd0, 1'b0, a, 32'd0, 1'b0);
    endtask

    initial begin
        logic [4:0]  ec, a;
        logic        w, er;
        logic [5:0]  hw;
        logic [4:0]  codes [4];
        codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
        model_reset();
        exc_code = 0; m_pc = 0; m_bd = 0; hw_int = 0; we = 0; addr = 0; wdata = 0; eret = 0;
        reset = 1'b0;
        #2;
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_exl", {31'b0, exl}, 32'd0);
        chk("rst_epc", epc_out, 32'd0);
        addr = 5'd12; #0.5 chk("rst_sr", rdata, 32'd0);
        addr = 5'd13; #0.5 chk("rst_cause", rdata, 32'd0);
        addr = 5'd15; #0.5 chk("rst_prid", rdata, PRID);
        #8 reset = 1'b1;

        // interrupt entry
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
        cyc(5'd0, 32'h0000_3008, 1'b0, 6'd1, 1'b0, 5'd14, 32'd0, 1'b0);
        idle(5'd14);
        idle(5'd13);
        // exception ignored in handler, then eret with interrupt held off in RETURN
        cyc(5'd10, 32'h0000_3100, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
        cyc(5'd0, 32'h0000_3104, 1'b0, 6'd1, 1'b0, 5'd14, 32'd0, 1'b1);
        cyc(5'd0, 32'h0000_3008, 1'b0, 6'd1, 1'b0, 5'd12, 32'd0, 1'b0);
        cyc(5'd0, 32'h0000_300C, 1'b0, 6'd1, 1'b0, 5'd14, 32'd0, 1'b0);
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0, 1'b0);
        // overflow in a delay slot
        cyc(5'd12, 32'h0000_3010, 1'b1, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        idle(5'd13);
        idle(5'd14);
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0, 1'b0);
        // mtc0 to EPC dropped under a same-cycle exception
        cyc(5'd4, 32'h0000_3020, 1'b0, 6'd0, 1'b1, 5'd14, 32'h0000_1234, 1'b0);
        idle(5'd14);
        idle(5'd13);
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0, 1'b0);
        // SR write mask, Cause/PRId read-only
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0);
        idle(5'd12);
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0);
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd15, 32'hFFFF_FFFF, 1'b0);
        idle(5'd13);
        idle(5'd15);
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0, 1'b0);

        // randomized traffic (mtc0 and eret never share the M stage)
        for (int i = 0; i < 500; i++) begin
            ec = ($urandom_range(0, 9) < 6) ? 5'd0 : codes[$urandom_range(0, 3)];
            w  = ($urandom_range(0, 5) == 0);
            er = !w && ($urandom_range(0, 4) == 0);
            a  = 5'($urandom_range(10, 17));
            hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            cyc(ec, $urandom, 1'($urandom), hw, w, a, $urandom, er);
        end

        // asynchronous reset in the middle of a handler
        cyc(5'd0, 32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0, 1'b0);
        cyc(5'd12, 32'h0000_3200, 1'b0, 6'd3, 1'b0, 5'd14, 32'd0, 1'b0);
        idle(5'd14);
        @(negedge clk);
        exc_code = 0; hw_int = 0; we = 0; eret = 0;
        #2 reset = 1'b0;
        model_reset();
        #0.5;
        chk("arst_req", {31'b0, req}, 32'd0);
        chk("arst_exl", {31'b0, exl}, 32'd0);
        chk("arst_epc", epc_out, 32'd0);
        addr = 5'd12; #0.5 chk("arst_sr", rdata, 32'd0);
        addr = 5'd13; #0.5 chk("arst_cause", rdata, 32'd0);
        addr = 5'd14; #0.5 chk("arst_epc_rd", rdata, 32'd0);
        #4 reset = 1'b1;
        idle(5'd12);
        cyc(5'd5, 32'h0000_3300, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        idle(5'd13);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
